instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port wr_en, input, 1 bit: program-memory write strobe.
REQ-004 SHALL have port wr_addr, input, 4 bits: program-memory write address.
REQ-005 SHALL have port wr_data, input, 32 bits: instruction word laid out as opcode[31:24], dest[23:16], src2[15:8], src1[7:0].
REQ-006 SHALL have port prog_len, input, 5 bits: number of instructions to issue; values above 16 are treated as 16.
REQ-007 SHALL have port start, input, 1 bit: starts a run from address 0.
REQ-008 SHALL have port stall, input, 1 bit: holds the current issued instruction.
REQ-009 SHALL have port instruction, output, 32 bits: issued instruction word to the control unit.
REQ-010 SHALL have port instr_valid, output, 1 bit: instruction is valid this cycle.
REQ-011 SHALL have port pc, output, 4 bits: address of the issued instruction.
REQ-012 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-013 SHALL have port err, output, 1 bit: sticky illegal-opcode flag.

Function
REQ-014 SHALL contain 16 x 32-bit program memory, written on a rising edge when wr_en=1 and state=IDLE; writes in RUN are ignored.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE, start=1 with effective prog_len>0 SHALL move to RUN, clear err, and on the next edge present instruction=mem[0], pc=0, instr_valid=1.
REQ-017 In IDLE, start=1 with prog_len=0 SHALL go to DONE (done pulse, no issue).
REQ-018 In RUN with stall=0, each edge SHALL advance pc by 1 and present mem[pc+1]; one instruction per cycle, 1-cycle latency from memory to output.
REQ-019 In RUN with stall=1, instruction, pc and instr_valid SHALL hold unchanged.
REQ-020 When the instruction at pc=effective prog_len-1 is presented with stall=0, the next edge SHALL enter DONE with instr_valid=0.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-022 start asserted in RUN or DONE SHALL be ignored.
REQ-023 Whenever instr_valid=0, instruction SHALL be 32'h0.
REQ-024 pc SHALL never wrap; at prog_len=16 the last issued pc is 15.
REQ-025 A write to the address currently being issued SHALL NOT occur (writes are blocked in RUN), so issued words are stable.

Reset
REQ-026 RESET=1 SHALL immediately force state=IDLE, instruction=0, instr_valid=0, pc=0, done=0, err=0, including mid-run.
REQ-027 Program memory contents SHALL NOT be cleared by RESET.

Configuration
REQ-028 Macro INSTR_FETCH_OPCHECK_EN defined: a word about to be presented with opcode > 8'h05 SHALL NOT be issued; instead the fetcher asserts err=1 (sticky until next accepted start or RESET), sets instr_valid=0, returns to IDLE and emits no done pulse.
REQ-029 Macro INSTR_FETCH_OPCHECK_EN undefined: all opcodes SHALL be issued unchanged and err SHALL be tied to 0.

Verification
REQ-030 Load mem[0..2]=32'h00000006, 32'h00010002, 32'h01020001; prog_len=3; start -> three consecutive valid cycles pc=0,1,2 with those words, then done=1 for one cycle, instr_valid=0.
REQ-031 Same program, stall=1 for 2 cycles while pc=1 -> 32'h00010002 held 3 cycles total, then pc=2, done one cycle later.
REQ-032 prog_len=0, start -> no instr_valid, done=1 exactly one cycle after start sampled.
REQ-033 During RUN, wr_en=1 to address 1 with 32'hFFFFFFFF -> ignored; a second run issues the original word.
REQ-034 RESET pulse while pc=1 -> all outputs 0 immediately; subsequent start re-issues from pc=0 with memory intact.
REQ-035 With INSTR_FETCH_OPCHECK_EN, mem[1]=32'h07000000, prog_len=3 -> pc=0 issued, then err=1, instr_valid=0, no done; without macro -> word issued at pc=1, err=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetcher: 16x32 program memory streamed to the control unit one word per cycle.
// Optional macro INSTR_FETCH_OPCHECK_EN enables illegal-opcode trapping (opcode > 8'h05) with a sticky err flag.
module instr_fetch (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  prog_len,
  input  logic        start,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [3:0]  pc,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instruction_q, instruction_d;
  logic        instr_valid_q, instr_valid_d;
  logic [3:0]  pc_q, pc_d;
  logic [3:0]  last_q, last_d;
  logic        done_q, done_d;

  logic [31:0] mem [16];
  logic [4:0]  eff_len;
  logic [4:0]  len_m1;
  logic [3:0]  fetch_addr;
  logic [31:0] fetch_word;
  logic        fetch_illegal;
  logic        issue;

  assign eff_len = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign len_m1  = eff_len - 5'd1;

  // The first issue of a run always reads address 0; afterwards the word following pc.
  assign fetch_addr = instr_valid_q ? (pc_q + 4'd1) : 4'd0;
  assign fetch_word = mem[fetch_addr];

  // Program memory is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge CLK) begin
    if (wr_en && (state_q == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    pc_d          = pc_q;
    last_d        = last_q;
    done_d        = 1'b0;
    issue         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_len == 5'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            last_d  = len_m1[3:0];
          end
        end
      end

      RUN: begin
        if (!instr_valid_q) begin
          issue = 1'b1;
        end else if (!stall) begin
          if (pc_q == last_q) begin
            state_d       = DONE;
            done_d        = 1'b1;
            instr_valid_d = 1'b0;
            instruction_d = 32'h0;
          end else begin
            issue = 1'b1;
          end
        end

        if (issue) begin
          if (fetch_illegal) begin
            // Trapped word is never presented; the run is abandoned without a done pulse.
            state_d       = IDLE;
            instr_valid_d = 1'b0;
            instruction_d = 32'h0;
          end else begin
            instruction_d = fetch_word;
            instr_valid_d = 1'b1;
            pc_d          = fetch_addr;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      instruction_q <= 32'h0;
      instr_valid_q <= 1'b0;
      pc_q          <= 4'd0;
      last_q        <= 4'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      last_q        <= last_d;
      done_q        <= done_d;
    end
  end

`ifdef INSTR_FETCH_OPCHECK_EN
  logic err_q, err_d;

  assign fetch_illegal = (fetch_word[31:24] > 8'h05);

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end else if ((state_q == RUN) && issue && fetch_illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign fetch_illegal = 1'b0;
  assign err           = 1'b0;
`endif

  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program runs plus randomized programs, lengths and stalls
// compared against an expected-issue-stream model.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        stall;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Reference view of program memory: only writes made while the fetcher is idle land here.
  logic [31:0] exp_mem [16];

  instr_fetch dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .prog_len    (prog_len),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .done        (done),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_quiet(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "/instr"}, instruction, 32'd0);
    chk({tag, "/done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "/err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic expect_issue(input string tag, input int idx);
    chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "/pc"}, {28'd0, pc}, 32'(idx));
    chk({tag, "/instr"}, instruction, exp_mem[idx]);
    chk({tag, "/done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic load(input int a, input logic [31:0] w);
    wr_en   = 1'b1;
    wr_addr = a[3:0];
    wr_data = w;
    step();
    wr_en   = 1'b0;
    exp_mem[a] = w;
  endtask

  task automatic load_random_program();
    logic [31:0] w;
    logic [7:0]  op;
    for (int a = 0; a < 16; a++) begin
      w = $urandom();
`ifdef INSTR_FETCH_OPCHECK_EN
      op = 8'($urandom_range(5));
      w[31:24] = op;
`else
      op = w[31:24];
`endif
      load(a, w);
    end
  endtask

  // One complete run. Expected behaviour: issue words 0..eff-1 in order, each held while stalled,
  // then a single done cycle and a return to idle.
  task automatic run(input string tag, input int len, input int stall_pct,
                     input int stall_at, input bit poke);
    int eff;
    int idx;
    int cyc;
    int held;
    bit s;
    bit poked;
    bit finished;
    eff = (len > 16) ? 16 : len;
    prog_len = len[4:0];
    start    = 1'b1;
    stall    = 1'b0;
    step();
    start = 1'b0;
    if (eff == 0) begin
      expect_quiet({tag, " start"}, 1'b1, 1'b0);
      step();
      expect_quiet({tag, " idle"}, 1'b0, 1'b0);
      $display("run %s: len=%0d eff=0 -> immediate done", tag, len);
      return;
    end
    expect_quiet({tag, " armed"}, 1'b0, 1'b0);
    step();
    idx = 0;
    expect_issue({tag, " issue"}, idx);
    cyc = 0;
    held = 0;
    poked = 1'b0;
    finished = 1'b0;
    while (!finished && cyc < 200) begin
      s = ($urandom_range(99) < stall_pct);
      if (idx == stall_at && held < 2) begin
        s = 1'b1;
        held++;
      end
      stall = s;
      if (poke && !poked && idx == 1) begin
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 32'hFFFF_FFFF;
        poked   = 1'b1;
      end
      step();
      wr_en = 1'b0;
      cyc++;
      if (!s) idx++;
      if (idx == eff) begin
        expect_quiet({tag, " end"}, 1'b1, 1'b0);
        finished = 1'b1;
      end else begin
        expect_issue({tag, " issue"}, idx);
      end
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $error("FAIL %s timeout: observed %0d cycles without completion, expected %0d issues", tag, cyc, eff);
    end
    stall = 1'b0;
    step();
    expect_quiet({tag, " idle"}, 1'b0, 1'b0);
    $display("run %s: len=%0d eff=%0d cycles=%0d poke=%0d", tag, len, eff, cyc, poke);
  endtask

  initial begin
    RESET    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 32'h0;
    prog_len = 5'd0;
    start    = 1'b0;
    stall    = 1'b0;
    step();
    expect_quiet("reset", 1'b0, 1'b0);
    chk("reset/pc", {28'd0, pc}, 32'd0);
    RESET = 1'b0;
    step();

    // Basic three-word program, no stalls.
    load(0, 32'h0000_0006);
    load(1, 32'h0001_0002);
    load(2, 32'h0102_0001);
    run("basic", 3, 0, -1, 1'b0);

    // Two-cycle stall while pc=1.
    run("stall_pc1", 3, 0, 1, 1'b0);

    // Zero-length program.
    run("len0", 0, 0, -1, 1'b0);

    // Write attempted mid-run must not land; the following run sees the original word.
    run("poke", 3, 0, -1, 1'b1);
    run("after_poke", 3, 0, -1, 1'b0);

    // Asynchronous reset while pc=1, then restart with memory intact.
    prog_len = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    expect_issue("pre_reset", 0);
    step();
    expect_issue("pre_reset", 1);
    RESET = 1'b1;
    #1;
    expect_quiet("async_reset", 1'b0, 1'b0);
    chk("async_reset/pc", {28'd0, pc}, 32'd0);
    #1;
    RESET = 1'b0;
    step();
    expect_quiet("post_reset", 1'b0, 1'b0);
    $display("reset mid-run at pc=1 applied");
    run("after_reset", 3, 0, -1, 1'b0);

    // Illegal opcode at address 1.
    load(1, 32'h0700_0000);
`ifdef INSTR_FETCH_OPCHECK_EN
    prog_len = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    expect_quiet("trap armed", 1'b0, 1'b0);
    step();
    expect_issue("trap", 0);
    step();
    expect_quiet("trap hit", 1'b0, 1'b1);
    step();
    expect_quiet("trap sticky", 1'b0, 1'b1);
    $display("illegal opcode trapped at pc=1");
    load(1, 32'h0001_0002);
    run("after_trap", 3, 0, -1, 1'b0);
`else
    run("op07", 3, 0, -1, 1'b0);
`endif

    // Full-length and over-length programs, then randomized runs.
    load_random_program();
    run("len16", 16, 0, -1, 1'b0);
    run("len20", 20, 25, 15, 1'b0);
    for (int r = 0; r < 10; r++) begin
      load_random_program();
      run($sformatf("rand%0d", r), int'($urandom_range(20)), int'($urandom_range(40)),
          int'($urandom_range(15)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
